io_periph_ctrl: RTL and testbench
=================================

Name: io_periph_ctrl

Overview:
- Parametrised peripheral block beside the RV32I core inside fpga_top, replacing hard-wired pins with two register-controlled functions.
- Interrupt side: NUM_IRQ asynchronous interrupt pins (generalising interrupt_0), each with a synchronizer, a configurable edge/level detector, a pending latch, an enable mask and one combined irq line to the core.
- LED side: NUM_LED PWM-dimmed LED outputs (generalising rgb_led/rgb_led1) with shared prescaler and glitch-free duty update.
- Accessed through the core's word-addressed I/O bus.

Parameters:
- NUM_IRQ, 2, interrupt input count (1..8).
- NUM_LED, 6, LED channel count (1..8).
- PWM_W, 8, PWM counter/duty width (2..16).
- SYNC_STAGES, 2, synchronizer flops per interrupt input (2..4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- irq_in  in  NUM_IRQ  asynchronous interrupt pins.
- irq_out  out  1  registered OR of (pending & enable) to core.
- we  in  1  register write strobe, single cycle.
- re  in  1  register read strobe, single cycle.
- adr  in  4  word register index.
- wdata  in  32  write data.
- rdata  out  32  read data, registered.
- led_out  out  NUM_LED  PWM LED drive, registered.

Behaviour:
- Interface: one clock clk; reset rst is synchronous, active-high.
- Reset: every flop → 0, including sync chains, pending, enable, mode, prescale, duty/shadow, counters.
- Outputs after reset: irq_out=0, rdata=0, led_out=0.
- Register map (unmapped index reads 0, writes ignored; bits above channel count read 0):
  - 0x0 IRQ_PEND, R/W1C.
  - 0x1 IRQ_EN, RW.
  - 0x2 IRQ_MODE, RW, 2 bits per channel i at [2i+1:2i]: 00 rising, 01 falling, 10 both edges, 11 level-high.
  - 0x3 IRQ_RAW, R: synchronized levels.
  - 0x4 PRESCALE, RW, [15:0].
  - 0x8+i LED_DUTY i, RW, [PWM_W-1:0]. Reads return the written value, not the active shadow.
- Read: re at edge k → rdata valid after edge k+1. rdata holds its value until the next re. we and re in the same cycle: write applies, read returns the pre-write value.
- Write: takes effect at the edge where we is sampled.
- Interrupt path, per channel:
  - Edge 1 captures the pin into sync[0]. sync[S-1] and a prev flop are then compared combinationally.
  - Pending set at edge S+1 after the input change; irq_out rises one edge later.
  - Default S=2: pending at edge 3, irq_out at edge 4.
- W1C: clears pending bits written as 1.
  - Set and W1C on the same bit in the same cycle: set wins.
  - Level mode: set asserts every cycle the level is high, so W1C clears only once the input is low.
- Masking: IRQ_EN masks irq_out only; pending still latches while disabled.
- Mode change: does not clear pending.
- PWM timing:
  - Prescale counter counts 0..PRESCALE and emits tick on the terminal count, then returns to 0. PRESCALE=0 gives a tick every cycle.
  - pwm_cnt (PWM_W bits) increments on tick and wraps 2^PWM_W-1 → 0.
- PWM duty:
  - Written duty goes to a shadow register. The shadow loads into the active duty on the tick that wraps pwm_cnt to 0, so there are no mid-period glitches.
  - led_out[i] registered = (pwm_cnt < active_duty[i]). Duty 0 = constant off; duty 2^PWM_W-1 = high for all but one slot per period.
- PRESCALE write resets the prescale counter to 0 in the same edge; pwm_cnt is not reset.
- Reset mid-operation: every register returns to its reset value on the reset edge, regardless of pending writes or in-flight edges. A pin held high through reset release does not produce a rising edge, because sync and prev both fill with 1.

Test Plan:
- Reset: assert rst 2 cycles with irq_in=2'b11 → irq_out=0, led_out=0, rdata=0, all registers read 0. Release; level held high → no rising-edge pending.
- Rising edge: EN=1, MODE=00, irq_in[0] 0→1 after edge k → PEND=1 at edge k+3, irq_out=1 at k+4.
  - W1C 0x1 → irq_out=0 two edges later.
  - W1C in the same cycle as a new detected edge → PEND stays 1.
- Modes on ch1: MODE=01 (falling) sets only on 1→0; MODE=10 sets on both edges.
  - MODE=11 with input high: W1C does not clear; after input low, W1C clears.
  - EN=0 → PEND latches, irq_out stays 0.
- PWM, PWM_W=8, PRESCALE=0:
  - LED_DUTY0=64 → 64 high cycles per 256.
  - Duty 0 → always low; duty 255 → 255 high of 256.
  - PRESCALE=3 → period 1024 cycles.
- Glitch-free update: write duty 200 while pwm_cnt=100 with old duty 50 → led_out pattern changes only from the next period start. Readback of 0x8 is 200 immediately.
- Read behaviour: simultaneous we/re to 0x1 → read returns the old value. Reads of 0x5 and 0xF (NUM_LED=6) return 0.

Source files
------------

// File: rtl/io_periph_ctrl.sv
// Peripheral block beside the RV32I core: masked edge/level interrupt inputs plus
// PWM-dimmed LED channels, all behind a small word-addressed register file.
`timescale 1ns/1ps
module io_periph_ctrl #(
    parameter int NUM_IRQ     = 2,
    parameter int NUM_LED     = 6,
    parameter int PWM_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq_out,
    input  logic               we,
    input  logic               re,
    input  logic [3:0]         adr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic [NUM_LED-1:0] led_out
);

    logic [NUM_IRQ-1:0]   sync_q [SYNC_STAGES];
    logic [SYNC_STAGES:0] arm_q;
    logic [NUM_IRQ-1:0]   prev_q;
    logic [NUM_IRQ-1:0]   pend_q, pend_d;
    logic [NUM_IRQ-1:0]   en_q;
    logic [2*NUM_IRQ-1:0] mode_q;
    logic                 irq_q;
    logic [31:0]          rdata_q, rdata_d;

    logic [15:0]          prescale_q;
    logic [15:0]          prescCnt_q, prescCnt_d;
    logic [PWM_W-1:0]     pwmCnt_q;
    logic [PWM_W-1:0]     shadow_q [NUM_LED];
    logic [PWM_W-1:0]     activeDuty_q [NUM_LED];
    logic [NUM_LED-1:0]   led_q;

    logic [NUM_IRQ-1:0]   syncLevel, riseDet, fallDet, setMask;
    logic                 wrPend, wrEn, wrMode, wrPresc;
    logic                 tick, wrap;
    logic                 unusedWdata;

    assign wrPend  = we && (adr == 4'h0);
    assign wrEn    = we && (adr == 4'h1);
    assign wrMode  = we && (adr == 4'h2);
    assign wrPresc = we && (adr == 4'h4);

    assign unusedWdata = ^wdata;

    // arm_q fills with ones after reset so edges are only detected once both the
    // last sync stage and prev_q hold real pin samples (no false edge at release).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            arm_q  <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign syncLevel = sync_q[SYNC_STAGES-1];
    assign riseDet   = syncLevel & ~prev_q;
    assign fallDet   = ~syncLevel & prev_q;

    always_comb begin
        setMask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            case (mode_q[2*i +: 2])
                2'b00:   setMask[i] = riseDet[i];
                2'b01:   setMask[i] = fallDet[i];
                2'b10:   setMask[i] = riseDet[i] | fallDet[i];
                default: setMask[i] = syncLevel[i];
            endcase
        end
        setMask = setMask & {NUM_IRQ{arm_q[SYNC_STAGES]}};
        // a new event outranks a W1C to the same bit in the same cycle
        pend_d = (pend_q & ~(wrPend ? wdata[NUM_IRQ-1:0] : '0)) | setMask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q     <= '0;
            en_q       <= '0;
            mode_q     <= '0;
            prescale_q <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            pend_q  <= pend_d;
            irq_q   <= |(pend_q & en_q);
            rdata_q <= rdata_d;
            if (wrEn)    en_q       <= wdata[NUM_IRQ-1:0];
            if (wrMode)  mode_q     <= wdata[2*NUM_IRQ-1:0];
            if (wrPresc) prescale_q <= wdata[15:0];
        end
    end

    // Reads see the pre-write register values when we and re coincide.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = '0;
            case (adr)
                4'h0:    rdata_d[NUM_IRQ-1:0]   = pend_q;
                4'h1:    rdata_d[NUM_IRQ-1:0]   = en_q;
                4'h2:    rdata_d[2*NUM_IRQ-1:0] = mode_q;
                4'h3:    rdata_d[NUM_IRQ-1:0]   = syncLevel;
                4'h4:    rdata_d[15:0]          = prescale_q;
                default: begin
                    for (int i = 0; i < NUM_LED; i++) begin
                        if (adr == 4'(8 + i)) rdata_d[PWM_W-1:0] = shadow_q[i];
                    end
                end
            endcase
        end
    end

    assign tick = (prescCnt_q == prescale_q);
    assign wrap = tick && (pwmCnt_q == '1);

    always_comb begin
        prescCnt_d = prescCnt_q + 16'd1;
        if (wrPresc || tick) prescCnt_d = '0;
    end

    // Shadow duties only become active at the period boundary, keeping each period clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            prescCnt_q <= '0;
            pwmCnt_q   <= '0;
            led_q      <= '0;
            for (int i = 0; i < NUM_LED; i++) begin
                shadow_q[i]     <= '0;
                activeDuty_q[i] <= '0;
            end
        end else begin
            prescCnt_q <= prescCnt_d;
            if (tick) pwmCnt_q <= pwmCnt_q + PWM_W'(1);
            for (int i = 0; i < NUM_LED; i++) begin
                if (we && (adr == 4'(8 + i))) shadow_q[i] <= wdata[PWM_W-1:0];
                if (wrap) activeDuty_q[i] <= shadow_q[i];
                led_q[i] <= (pwmCnt_q < activeDuty_q[i]);
            end
        end
    end

    assign irq_out = irq_q;
    assign rdata   = rdata_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_io_periph_ctrl.sv
// Directed self-checking bench for io_periph_ctrl: register access, interrupt
// detection modes, masking, PWM duty counts and shadowed duty updates.
`timescale 1ns/1ps
module tb_io_periph_ctrl;

    localparam int NUM_IRQ = 2;
    localparam int NUM_LED = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_IRQ-1:0] irq_in;
    logic               irq_out;
    logic               we, re;
    logic [3:0]         adr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic [NUM_LED-1:0] led_out;

    int passCount  = 0;
    int checkCount = 0;
    int highs;
    int guard;

    io_periph_ctrl #(
        .NUM_IRQ(NUM_IRQ), .NUM_LED(NUM_LED), .PWM_W(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_out(irq_out),
        .we(we), .re(re), .adr(adr), .wdata(wdata), .rdata(rdata), .led_out(led_out)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    // Drive one bus cycle starting from a falling edge; returns on the next falling edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
        we = w; re = r; adr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
    endtask

    // Count led_out[0] high samples over n cycles.
    task automatic countHigh(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (led_out[0] === 1'b1) cnt++;
        end
    endtask

    // Hard stop in case anything wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; irq_in = 2'b11; we = 1'b0; re = 1'b0; adr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("rstIrqOut", {31'd0, irq_out}, 32'd0);
        checkOutput("rstLedOut", {26'd0, led_out}, 32'd0);
        checkOutput("rstRdata", rdata, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        applyStimulus(0, 1, 4'h0, 0); checkOutput("rstPendNoEdge", rdata, 32'd0);
        applyStimulus(0, 1, 4'h1, 0); checkOutput("rstEn", rdata, 32'd0);
        applyStimulus(0, 1, 4'h2, 0); checkOutput("rstMode", rdata, 32'd0);
        applyStimulus(0, 1, 4'h4, 0); checkOutput("rstPrescale", rdata, 32'd0);
        applyStimulus(0, 1, 4'h8, 0); checkOutput("rstDuty0", rdata, 32'd0);
        applyStimulus(0, 1, 4'h3, 0); checkOutput("rawLevels", rdata, 32'd3);

        // rising edge on ch0 with precise latency
        applyStimulus(1, 0, 4'h1, 32'd1);
        irq_in = 2'b00;
        repeat (4) @(negedge clk);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("fallIgnoredRiseMode", rdata, 32'd0);
        irq_in = 2'b01;
        @(negedge clk); checkOutput("irqK1", {31'd0, irq_out}, 32'd0);
        @(negedge clk); checkOutput("irqK2", {31'd0, irq_out}, 32'd0);
        @(negedge clk); checkOutput("irqK3", {31'd0, irq_out}, 32'd0);
        applyStimulus(0, 1, 4'h0, 0);
        checkOutput("pendK4", rdata, 32'd1);
        checkOutput("irqK4", {31'd0, irq_out}, 32'd1);

        applyStimulus(1, 0, 4'h0, 32'd1);
        checkOutput("irqAfterW1cEdge", {31'd0, irq_out}, 32'd1);
        @(negedge clk);
        checkOutput("irqClearedW1c", {31'd0, irq_out}, 32'd0);

        // W1C lands on the same edge as a fresh rising edge
        irq_in = 2'b00;
        repeat (4) @(negedge clk);
        irq_in = 2'b01;
        repeat (2) @(negedge clk);
        applyStimulus(1, 0, 4'h0, 32'd1);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("w1cSetWins", rdata, 32'd1);
        applyStimulus(1, 0, 4'h0, 32'd3);

        // ch1 mode tests (ch0 held high, no further events)
        applyStimulus(1, 0, 4'h2, 32'h4);
        irq_in = 2'b11; repeat (5) @(negedge clk);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("fallModeIgnoresRise", rdata, 32'd0);
        irq_in = 2'b01; repeat (5) @(negedge clk);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("fallModeSets", rdata, 32'd2);
        applyStimulus(1, 0, 4'h0, 32'd2);

        applyStimulus(1, 0, 4'h2, 32'h8);
        irq_in = 2'b11; repeat (5) @(negedge clk);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("bothModeRise", rdata, 32'd2);
        applyStimulus(1, 0, 4'h0, 32'd2);
        irq_in = 2'b01; repeat (5) @(negedge clk);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("bothModeFall", rdata, 32'd2);
        applyStimulus(1, 0, 4'h0, 32'd2);

        applyStimulus(1, 0, 4'h2, 32'hC);
        irq_in = 2'b11; repeat (5) @(negedge clk);
        applyStimulus(1, 0, 4'h0, 32'd2);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("levelW1cHolds", rdata, 32'd2);
        checkOutput("ch1MaskedIrq", {31'd0, irq_out}, 32'd0);
        irq_in = 2'b01; repeat (5) @(negedge clk);
        applyStimulus(1, 0, 4'h0, 32'd2);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("levelW1cClears", rdata, 32'd0);

        // pending still latches while disabled
        applyStimulus(1, 0, 4'h1, 32'd0);
        irq_in = 2'b00; repeat (4) @(negedge clk);
        irq_in = 2'b01; repeat (6) @(negedge clk);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("pendWhileMasked", rdata, 32'd1);
        checkOutput("irqWhileMasked", {31'd0, irq_out}, 32'd0);
        applyStimulus(0, 1, 4'h2, 0); checkOutput("modeRead", rdata, 32'hC);

        // read behaviour
        applyStimulus(1, 1, 4'h1, 32'd1); checkOutput("rdWrSameOld", rdata, 32'd0);
        applyStimulus(0, 1, 4'h1, 0); checkOutput("rdAfterWr", rdata, 32'd1);
        @(negedge clk); checkOutput("rdataHolds", rdata, 32'd1);
        applyStimulus(1, 0, 4'h1, 32'hFFFF_FFFF);
        applyStimulus(0, 1, 4'h1, 0); checkOutput("enUpperBits", rdata, 32'd3);
        applyStimulus(0, 1, 4'h5, 0); checkOutput("unmapped5", rdata, 32'd0);
        applyStimulus(1, 0, 4'hE, 32'hFF);
        applyStimulus(0, 1, 4'hE, 0); checkOutput("unmappedE", rdata, 32'd0);
        applyStimulus(0, 1, 4'hF, 0); checkOutput("unmappedF", rdata, 32'd0);
        applyStimulus(1, 0, 4'hD, 32'h1_80);
        applyStimulus(0, 1, 4'hD, 0); checkOutput("duty5Read", rdata, 32'h80);
        applyStimulus(1, 0, 4'hD, 32'd0);

        // PWM duty counts, prescale 0
        applyStimulus(1, 0, 4'h8, 32'd64);
        repeat (600) @(negedge clk);
        countHigh(256, highs); checkOutput("duty64", 32'(highs), 32'd64);
        checkOutput("otherLedsOff", {27'd0, led_out[5:1]}, 32'd0);
        applyStimulus(1, 0, 4'h8, 32'd0);
        repeat (600) @(negedge clk);
        countHigh(256, highs); checkOutput("duty0", 32'(highs), 32'd0);
        applyStimulus(1, 0, 4'h8, 32'd255);
        repeat (600) @(negedge clk);
        countHigh(256, highs); checkOutput("duty255", 32'(highs), 32'd255);

        // glitch-free update: find the 50->51 boundary, then write 200 mid-period
        applyStimulus(1, 0, 4'h8, 32'd50);
        repeat (600) @(negedge clk);
        guard = 0;
        while (led_out[0] !== 1'b1 && guard < 600) begin @(negedge clk); guard++; end
        while (led_out[0] !== 1'b0 && guard < 1200) begin @(negedge clk); guard++; end
        checkOutput("findPeriodPhase", {31'd0, guard < 1200}, 32'd1);
        highs = 0;
        we = 1'b1; adr = 4'h8; wdata = 32'd200;
        for (int i = 0; i < 205; i++) begin
            @(negedge clk);
            if (led_out[0] === 1'b1) highs++;
            if (i == 0) begin we = 1'b0; re = 1'b1; adr = 4'h8; end
            if (i == 1) begin re = 1'b0; checkOutput("dutyReadImmediate", rdata, 32'd200); end
        end
        checkOutput("oldPeriodStaysLow", 32'(highs), 32'd0);
        countHigh(256, highs); checkOutput("newPeriodDuty200", 32'(highs), 32'd200);

        // prescale 3 stretches the period to 1024 cycles
        applyStimulus(1, 0, 4'h4, 32'd3);
        applyStimulus(1, 0, 4'h8, 32'd64);
        applyStimulus(0, 1, 4'h4, 0); checkOutput("prescaleRead", rdata, 32'd3);
        repeat (2100) @(negedge clk);
        countHigh(1024, highs); checkOutput("prescale3Duty64", 32'(highs), 32'd256);

        // reset in the middle of operation
        checkOutput("irqBeforeReset", {31'd0, irq_out}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midRstIrq", {31'd0, irq_out}, 32'd0);
        checkOutput("midRstLed", {26'd0, led_out}, 32'd0);
        checkOutput("midRstRdata", rdata, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        applyStimulus(0, 1, 4'h8, 0); checkOutput("midRstDuty", rdata, 32'd0);
        applyStimulus(0, 1, 4'h0, 0); checkOutput("midRstPend", rdata, 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
